pc_sequencer: RTL and testbench

Fetch sequencer that owns the 16-bit program counter of the single-cycle/multi-cycle core and drives the instruction-memory fetch handshake. Each cycle it selects the next PC from sequential, branch, jump, interrupt and return sources, honours pipeline stalls, and waits on a variable-latency memory. It sits between the control unit (which supplies redirects and stall) and instruction memory, replacing free-running PC update with a controlled fetch loop.

---
 rtl/pc_seq_pkg.sv | 22 ++
 rtl/pc_seq_if.sv | 31 +++
 rtl/pc_next_sel.sv | 44 ++++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the pc_sequencer fetch block.
package pc_seq_pkg;

  localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'h0000;
  localparam logic [15:0] DEFAULT_IRQ_VECTOR   = 16'h0040;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD,
    HALTED
  } state_t;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BRANCH,
    SRC_JUMP,
    SRC_IRQ,
    SRC_RET
  } next_src_t;

endpackage

// File: rtl/pc_seq_if.sv
// Fetch/control bundle between pc_sequencer, instruction memory and control unit.
interface pc_seq_if #(
  parameter int WIDTH = 16
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ready;
  logic             instr_valid;
  logic             stall;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             halt;
  logic             irq;
  logic             irq_ret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] epc;

  modport master (
    output imem_req, imem_addr, instr_valid, pc, epc,
    input  imem_ready, stall, branch_taken, branch_target,
           jump, jump_target, halt, irq, irq_ret
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, pc, epc,
    output imem_ready, stall, branch_taken, branch_target,
           jump, jump_target, halt, irq, irq_ret
  );
endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: irq_ret > irq > jump > branch > pc+1.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] IRQ_VECTOR = WIDTH'(DEFAULT_IRQ_VECTOR)
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] epc,
  input  logic             irq_ret,
  input  logic             irq_take,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] next_pc,
  output logic [WIDTH-1:0] normal_pc,
  output next_src_t        src
);

  // normal_pc is the target ignoring interrupts; it becomes epc when an irq is taken.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    normal_pc = pc + WIDTH'(1);
    src       = SRC_SEQ;
    if (jump) begin
      normal_pc = jump_target;
      src       = SRC_JUMP;
    end else if (branch_taken) begin
      normal_pc = branch_target;
      src       = SRC_BRANCH;
    end

    next_pc = normal_pc;
    if (irq_ret) begin
      next_pc = epc;
      src     = SRC_RET;
    end else if (irq_take) begin
      next_pc = IRQ_VECTOR;
      src     = SRC_IRQ;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the PC and drives the instruction-memory handshake.
// Interrupt support (ie flag, epc, irq/irq_ret) is built only when PC_SEQ_IRQ_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [WIDTH-1:0] IRQ_VECTOR   = WIDTH'(DEFAULT_IRQ_VECTOR)
) (
  input logic       clk,
  input logic       rst,
  pc_seq_if.master  bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q;
  logic [WIDTH-1:0] next_pc, normal_pc;
  next_src_t        src;
  logic             advance;
  logic             req, valid;
  logic             irq_take, ret_take;

`ifdef PC_SEQ_IRQ_EN
  logic             ie_q, ie_d;
  logic [WIDTH-1:0] epc_d;

  assign irq_take = bus.irq & ie_q;
  assign ret_take = bus.irq_ret;
`else
  logic unused_irq_path;

  assign irq_take        = 1'b0;
  assign ret_take        = 1'b0;
  assign epc_q           = '0;
  assign unused_irq_path = ^{bus.irq, bus.irq_ret, normal_pc, src};
`endif

  pc_next_sel #(
    .WIDTH      (WIDTH),
    .IRQ_VECTOR (IRQ_VECTOR)
  ) u_next_sel (
    .pc            (pc_q),
    .epc           (epc_q),
    .irq_ret       (ret_take),
    .irq_take      (irq_take),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .next_pc       (next_pc),
    .normal_pc     (normal_pc),
    .src           (src)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req     = 1'b0;
    valid   = 1'b0;
    advance = 1'b0;
`ifdef PC_SEQ_IRQ_EN
    epc_d   = epc_q;
    ie_d    = ie_q;
`endif

    case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: begin
        req = 1'b1;
        if (bus.imem_ready) begin
          valid = 1'b1;
          if (bus.stall) state_d = HOLD;
          else           advance = 1'b1;
        end
      end
      HOLD:  advance = !bus.stall;
      HALTED: begin
`ifdef PC_SEQ_IRQ_EN
        if (bus.irq && ie_q) begin
          epc_d   = pc_q;
          pc_d    = IRQ_VECTOR;
          ie_d    = 1'b0;
          state_d = FETCH;
        end
`endif
      end
    endcase

    // Redirects only matter here; outside an advance they are deliberately ignored.
    if (advance) begin
      pc_d    = next_pc;
      state_d = bus.halt ? HALTED : FETCH;
`ifdef PC_SEQ_IRQ_EN
      if (src == SRC_IRQ) begin
        epc_d = normal_pc;
        ie_d  = 1'b0;
      end else if (src == SRC_RET) begin
        ie_d  = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PC_SEQ_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_q <= '0;
      ie_q  <= 1'b1;
    end else begin
      epc_q <= epc_d;
      ie_q  <= ie_d;
    end
  end
`endif

  assign bus.imem_req    = req;
  assign bus.instr_valid = valid;
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.epc         = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer; interrupt scenarios run when PC_SEQ_IRQ_EN is defined.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  int          assertions = 0;
  int          failures   = 0;
  logic [15:0] sb[$];
  logic [15:0] exp_pc;

  pc_seq_if #(.WIDTH(16)) bus ();

  pc_sequencer #(
    .WIDTH        (16),
    .RESET_VECTOR (16'h0000),
    .IRQ_VECTOR   (16'h0040)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Every delivered instruction must match the oldest expected fetch address.
  always @(negedge clk) begin
    if (bus.instr_valid === 1'b1) begin
      assertions++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_valid: got instr_valid at addr %h, expected none", bus.imem_addr);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        if (bus.imem_addr !== e) begin
          failures++;
          $display("FAIL sb_addr: got %h, expected %h", bus.imem_addr, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.imem_ready    = 1'b1;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 16'h0000;
    bus.jump          = 1'b0;
    bus.jump_target   = 16'h0000;
    bus.halt          = 1'b0;
    bus.irq           = 1'b0;
    bus.irq_ret       = 1'b0;
  endtask

  task automatic run_to(input logic [15:0] target);
    while (exp_pc !== target) begin
      sb.push_back(exp_pc);
      #1;
      assertions++;
      if (bus.pc !== exp_pc) begin
        failures++;
        $display("FAIL seq_pc: got %h, expected %h", bus.pc, exp_pc);
      end
      step();
      exp_pc++;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    assertions++; if (bus.pc !== 16'h0000)    begin failures++; $display("FAIL reset_pc: got %h, expected 0000", bus.pc); end
    assertions++; if (bus.epc !== 16'h0000)   begin failures++; $display("FAIL reset_epc: got %h, expected 0000", bus.epc); end
    assertions++; if (bus.imem_req !== 1'b0)  begin failures++; $display("FAIL reset_req: got %b, expected 0", bus.imem_req); end
    assertions++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b, expected 0", bus.instr_valid); end
    rst = 1'b0;
    #1;
    assertions++; if (bus.imem_req !== 1'b0)  begin failures++; $display("FAIL boot_req: got %b, expected 0", bus.imem_req); end
    step();
    exp_pc = 16'h0000;
  endtask

  task automatic test_sequential();
    repeat (5) begin
      sb.push_back(exp_pc);
      #1;
      assertions++; if (bus.pc !== exp_pc)       begin failures++; $display("FAIL seq_first_pc: got %h, expected %h", bus.pc, exp_pc); end
      assertions++; if (bus.imem_req !== 1'b1)   begin failures++; $display("FAIL seq_req: got %b, expected 1", bus.imem_req); end
      assertions++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL seq_valid: got %b, expected 1", bus.instr_valid); end
      step();
      exp_pc++;
    end
  endtask

  task automatic test_wait_states();
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      assertions++; if (bus.pc !== 16'h0005)     begin failures++; $display("FAIL wait_pc: got %h, expected 0005", bus.pc); end
      assertions++; if (bus.imem_req !== 1'b1)   begin failures++; $display("FAIL wait_req: got %b, expected 1", bus.imem_req); end
      assertions++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL wait_valid: got %b, expected 0", bus.instr_valid); end
      step();
    end
    bus.imem_ready = 1'b1;
    sb.push_back(16'h0005);
    #1;
    assertions++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL wait_done_valid: got %b, expected 1", bus.instr_valid); end
    step();
    exp_pc = 16'h0006;
  endtask

  task automatic test_stall_jump();
    run_to(16'h0010);
    bus.stall = 1'b1;
    sb.push_back(16'h0010);
    #1;
    assertions++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL stall_done_valid: got %b, expected 1", bus.instr_valid); end
    step();
    for (int i = 0; i < 3; i++) begin
      bus.stall       = (i < 2);
      bus.jump        = 1'b1;
      bus.jump_target = (i < 2) ? 16'h0500 : 16'h0100;
      #1;
      assertions++; if (bus.pc !== 16'h0010)     begin failures++; $display("FAIL hold_pc: got %h, expected 0010", bus.pc); end
      assertions++; if (bus.imem_req !== 1'b0)   begin failures++; $display("FAIL hold_req: got %b, expected 0", bus.imem_req); end
      assertions++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL hold_valid: got %b, expected 0", bus.instr_valid); end
      step();
    end
    clear_inputs();
    exp_pc = 16'h0100;
    #1;
    assertions++; if (bus.pc !== 16'h0100) begin failures++; $display("FAIL jump_release_pc: got %h, expected 0100", bus.pc); end
  endtask

  task automatic test_priority_wrap();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0200;
    bus.jump          = 1'b1;
    bus.jump_target   = 16'h0300;
    sb.push_back(exp_pc);
    step();
    clear_inputs();
    exp_pc = 16'h0300;
    #1;
    assertions++; if (bus.pc !== 16'h0300) begin failures++; $display("FAIL jump_over_branch_pc: got %h, expected 0300", bus.pc); end
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'hFFFE;
    sb.push_back(exp_pc);
    step();
    clear_inputs();
    exp_pc = 16'hFFFE;
    #1;
    assertions++; if (bus.pc !== 16'hFFFE) begin failures++; $display("FAIL branch_pc: got %h, expected fffe", bus.pc); end
    run_to(16'h0002);
  endtask

`ifdef PC_SEQ_IRQ_EN
  task automatic test_irq();
    bus.jump        = 1'b1;
    bus.jump_target = 16'h0020;
    sb.push_back(exp_pc);
    step();
    clear_inputs();
    // irq taken alongside a branch: epc keeps the branch target
    bus.irq           = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0080;
    sb.push_back(16'h0020);
    step();
    bus.branch_taken = 1'b0;
    #1;
    assertions++; if (bus.pc !== 16'h0040)  begin failures++; $display("FAIL irq_pc: got %h, expected 0040", bus.pc); end
    assertions++; if (bus.epc !== 16'h0080) begin failures++; $display("FAIL irq_epc: got %h, expected 0080", bus.epc); end
    sb.push_back(16'h0040);
    step();
    #1;
    assertions++; if (bus.pc !== 16'h0041)  begin failures++; $display("FAIL irq_masked_pc: got %h, expected 0041", bus.pc); end
    bus.irq_ret = 1'b1;
    sb.push_back(16'h0041);
    step();
    bus.irq_ret = 1'b0;
    #1;
    assertions++; if (bus.pc !== 16'h0080)  begin failures++; $display("FAIL ret_pc: got %h, expected 0080", bus.pc); end
    sb.push_back(16'h0080);
    step();
    bus.irq = 1'b0;
    #1;
    assertions++; if (bus.pc !== 16'h0040)  begin failures++; $display("FAIL irq_after_ret_pc: got %h, expected 0040", bus.pc); end
    assertions++; if (bus.epc !== 16'h0081) begin failures++; $display("FAIL irq_after_ret_epc: got %h, expected 0081", bus.epc); end
    bus.irq_ret = 1'b1;
    sb.push_back(16'h0040);
    step();
    clear_inputs();
    exp_pc = 16'h0081;
    #1;
    assertions++; if (bus.pc !== 16'h0081)  begin failures++; $display("FAIL ret2_pc: got %h, expected 0081", bus.pc); end
  endtask
`else
  task automatic test_irq_ignored();
    bus.irq     = 1'b1;
    bus.irq_ret = 1'b1;
    sb.push_back(exp_pc);
    step();
    clear_inputs();
    exp_pc++;
    #1;
    assertions++; if (bus.pc !== exp_pc)    begin failures++; $display("FAIL irq_off_pc: got %h, expected %h", bus.pc, exp_pc); end
    assertions++; if (bus.epc !== 16'h0000) begin failures++; $display("FAIL irq_off_epc: got %h, expected 0000", bus.epc); end
  endtask
`endif

  task automatic test_halt_reset();
    bus.jump        = 1'b1;
    bus.jump_target = 16'h0030;
    sb.push_back(exp_pc);
    step();
    clear_inputs();
    bus.halt = 1'b1;
    sb.push_back(16'h0030);
    step();
    bus.halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      assertions++; if (bus.pc !== 16'h0031)     begin failures++; $display("FAIL halt_pc: got %h, expected 0031", bus.pc); end
      assertions++; if (bus.imem_req !== 1'b0)   begin failures++; $display("FAIL halt_req: got %b, expected 0", bus.imem_req); end
      step();
    end
`ifdef PC_SEQ_IRQ_EN
    bus.irq = 1'b1;
    step();
    bus.irq        = 1'b0;
    bus.imem_ready = 1'b0;
    #1;
    assertions++; if (bus.pc !== 16'h0040)     begin failures++; $display("FAIL halt_irq_pc: got %h, expected 0040", bus.pc); end
    assertions++; if (bus.epc !== 16'h0031)    begin failures++; $display("FAIL halt_irq_epc: got %h, expected 0031", bus.epc); end
    assertions++; if (bus.imem_req !== 1'b1)   begin failures++; $display("FAIL halt_irq_req: got %b, expected 1", bus.imem_req); end
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.imem_ready = 1'b1;
    #1;
    assertions++; if (bus.pc !== 16'h0000)      begin failures++; $display("FAIL rst2_pc: got %h, expected 0000", bus.pc); end
    assertions++; if (bus.epc !== 16'h0000)     begin failures++; $display("FAIL rst2_epc: got %h, expected 0000", bus.epc); end
    assertions++; if (bus.imem_req !== 1'b0)    begin failures++; $display("FAIL rst2_boot_req: got %b, expected 0", bus.imem_req); end
    assertions++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rst2_boot_valid: got %b, expected 0", bus.instr_valid); end
    step();
    exp_pc = 16'h0000;
    #1;
    assertions++; if (bus.imem_req !== 1'b1)    begin failures++; $display("FAIL rst2_fetch_req: got %b, expected 1", bus.imem_req); end
    run_to(16'h0002);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_stall_jump();
    test_priority_wrap();
`ifdef PC_SEQ_IRQ_EN
    test_irq();
`else
    test_irq_ignored();
`endif
    test_halt_reset();
    assertions++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
